word_detector_rx: RTL
=====================

Name: word_detector_rx

Overview:
- Receive end of the 8-bit ASCII word stream produced by the word transmitter (chip_SP).
- Samples one byte per qualified clock and tracks two fixed frames in parallel:
  - WORD_A, "Guatemala": 47 75 61 74 65 6D 61 6C 61 (9 bytes).
  - WORD_B, "QQuetza": 51 51 75 65 74 7A 61 (7 bytes).
- Reports per-word match pulses, wrapping match counters, the last word detected, and a lock/error indication against the word selected by `select`.

Parameters:
- CNT_W, 8, width of each match counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- q_in  in  8  received byte.
- in_valid  in  1  q_in qualifier; a byte is consumed only when high.
- select  in  2  expected word: 00/11 -> WORD_A, 01/10 -> WORD_B.
- match_a  out  1  one-cycle pulse: WORD_A completed.
- match_b  out  1  one-cycle pulse: WORD_B completed.
- count_a  out  CNT_W  WORD_A completions, wraps.
- count_b  out  CNT_W  WORD_B completions, wraps.
- last_word  out  2  00 none, 01 A, 10 B.
- locked  out  1  stream is aligned to the expected word.
- err  out  1  one-cycle pulse: expected word broken while locked.

Behaviour:
- Reset (asynchronous, active-high):
  - Both match indices cleared to 0.
  - match_a, match_b, err, locked = 0; count_a, count_b = 0; last_word = 00.
  - A reset mid-frame discards the partial frame.
- Matcher state: idx_a in 0..8, idx_b in 0..6; each is the number of frame bytes matched so far.
- When in_valid = 0: indices, counters, locked and last_word hold; all pulses deassert.
- When in_valid = 1, each matcher evaluates independently:
  - q_in equals the expected byte at idx and idx is not final: idx increments.
  - q_in equals the expected byte at final idx (A: 8, B: 6): completion. Set idx to 0 and pulse match_x on the next cycle.
  - Mismatch: idx falls back to the longest frame prefix that is a suffix of the received bytes.
    - WORD_A: q_in = 47 -> 1, else 0.
    - WORD_B: idx = 2 and q_in = 51 -> 2; else q_in = 51 -> 1; else 0.
- Latency: match_x is registered and asserts exactly 1 cycle after the final byte is sampled, for 1 cycle.
- Counters:
  - count_x increments on the same edge match_x asserts.
  - Wraps from 2^CNT_W-1 to 0; no saturation.
- last_word updates with each match. If both complete on the same edge, both count and last_word = 01 (A priority). This cannot occur with the fixed frames but must be handled deterministically.
- Back-to-back frames with no gap must each be detected; no frame shares bytes with the next.
- Lock state machine, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED on completion of the expected word.
  - LOCKED -> UNLOCKED on a consumed byte that causes a mismatch in the expected word's matcher. err pulses 1 cycle with the locked deassertion.
  - LOCKED -> UNLOCKED on any change of the decoded expected word (select 00<->11 and 01<->10 are not changes). No err pulse in this case.
  - Completion of the non-expected word does not affect locked.
  - When a select change and a completion happen on the same edge, the completion is evaluated against the new selection.
- Reset asserted mid-lock forces UNLOCKED with no err pulse.

Decomposition:
- Shared package word_pkg:
  - WORD_A / WORD_B byte constants as arrays with lengths 9 and 7.
  - Select encodings 00/11 -> A, 01/10 -> B.
  - last_word encodings.
  - Lock state typedef.
- One sub-module word_matcher:
  - Parameterized by frame length, frame bytes and fallback rule.
  - Ports: clk, reset, q_in, in_valid, done, mismatch.
  - Instantiated twice; top holds counters, last_word and the lock FSM.

Test Plan:
- Reset then stream "Guatemala" continuously with in_valid=1, select=00 -> match_a pulses 1 cycle after each 9th byte. count_a = 1, 2, 3; locked = 1 after the first pulse; err never asserts.
- select=01, stream "QQuetza" with a leading extra 51 (51 51 51 75 65 74 7A 61) -> one match_b pulse and count_b = 1 (fallback at idx 2 verified); match_a stays 0.
- Locked on A, then send 47 75 61 58 -> err pulses once and locked drops the cycle after 58; idx_a returns to 0, and the next full "Guatemala" relocks.
- in_valid toggled 0 between every byte of "Guatemala" -> the match still completes once, 1 cycle after the last valid byte; nothing changes during idle cycles.
- CNT_W=2, send 5 WORD_A frames -> count_a sequence 1, 2, 3, 0, 1.
- Assert reset after byte 5 of "Guatemala", release, then send a full frame -> only one match_a. All outputs read zero/00 during reset.

Source files
------------

// File: rtl/word_pkg.sv
// Shared constants for the word receiver: the two frames, select decoding,
// last_word encodings and the lock state type.
package word_pkg;

  localparam int WORD_A_LEN = 9;
  localparam int WORD_B_LEN = 7;

  // Index 0 is the first byte on the wire.
  localparam logic [0:WORD_A_LEN-1][7:0] WORD_A =
    {8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61};
  localparam logic [0:WORD_B_LEN-1][7:0] WORD_B =
    {8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61};

  typedef enum logic [1:0] {
    LW_NONE = 2'b00,
    LW_A    = 2'b01,
    LW_B    = 2'b10
  } last_word_t;

  typedef logic [0:0] lock_state_t;
  localparam lock_state_t UNLOCKED = 1'b0;
  localparam lock_state_t LOCKED   = 1'b1;

  // 00 and 11 select WORD_A, 01 and 10 select WORD_B.
  function automatic logic sel_is_a(input logic [1:0] sel);
    return (sel == 2'b00) || (sel == 2'b11);
  endfunction

endpackage

// File: rtl/word_matcher.sv
// Tracks progress through one fixed frame; flags completion and mismatch
// combinationally for the byte currently presented.
module word_matcher
  import word_pkg::*;
#(
  parameter int                     LEN             = 2,
  parameter logic [0:LEN-1][7:0]    FRAME           = '0,
  parameter bit                     PREFIX_FALLBACK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] q_in,
  input  logic       in_valid,
  output logic       done,
  output logic       mismatch
);

  localparam int IDX_W = $clog2(LEN);

  logic [IDX_W-1:0] idx_reg, idx_next, fallback;
  logic [7:0]       expected;
  logic             hit, final_byte, pre_ok;

  // On a mismatch at idx i, the new index is the longest k <= i such that
  // FRAME[0..k-1] equals FRAME[i-k+1..i-1] followed by q_in.
  always_comb begin
    expected = '0;
    fallback = '0;
    pre_ok   = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        expected = FRAME[i];
        if (PREFIX_FALLBACK) begin
          for (int k = 1; k <= i; k++) begin
            pre_ok = (q_in == FRAME[k-1]);
            for (int j = 0; j < k - 1; j++) begin
              if (FRAME[j] != FRAME[i-k+1+j]) pre_ok = 1'b0;
            end
            if (pre_ok) fallback = IDX_W'(k);
          end
        end
      end
    end
  end

  assign hit        = (q_in == expected);
  assign final_byte = (idx_reg == IDX_W'(LEN - 1));
  assign done       = in_valid && hit && final_byte;
  assign mismatch   = in_valid && !hit;

  always_comb begin
    idx_next = idx_reg;
    if (in_valid) begin
      if (hit) idx_next = final_byte ? '0 : idx_reg + IDX_W'(1);
      else     idx_next = fallback;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idx_reg <= '0;
    else       idx_reg <= idx_next;
  end

endmodule

// File: rtl/word_detector_rx.sv
// Receive-side word detector: two parallel frame matchers, match counters,
// last-word register and a lock tracker against the selected word.
module word_detector_rx
  import word_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       q_in,
  input  logic             in_valid,
  input  logic [1:0]       select,
  output logic             match_a,
  output logic             match_b,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic [1:0]       last_word,
  output logic             locked,
  output logic             err
);

  logic done_a, done_b, mis_a, mis_b;
  logic expect_a, sel_changed, exp_done, exp_mis, err_next;
  logic exp_a_reg, match_a_reg, match_b_reg, err_reg;
  logic [CNT_W-1:0] count_a_reg, count_b_reg;
  last_word_t  last_word_reg;
  lock_state_t state_reg, state_next;

  word_matcher #(.LEN(WORD_A_LEN), .FRAME(WORD_A), .PREFIX_FALLBACK(1'b1)) u_match_a (
    .clk(clk), .reset(reset), .q_in(q_in), .in_valid(in_valid),
    .done(done_a), .mismatch(mis_a)
  );

  word_matcher #(.LEN(WORD_B_LEN), .FRAME(WORD_B), .PREFIX_FALLBACK(1'b1)) u_match_b (
    .clk(clk), .reset(reset), .q_in(q_in), .in_valid(in_valid),
    .done(done_b), .mismatch(mis_b)
  );

  // Completion is judged against the selection presented this cycle.
  assign expect_a    = sel_is_a(select);
  assign sel_changed = (expect_a != exp_a_reg);
  assign exp_done    = expect_a ? done_a : done_b;
  assign exp_mis     = expect_a ? mis_a : mis_b;

  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    case (state_reg)
      UNLOCKED: if (exp_done) state_next = LOCKED;
      LOCKED: begin
        if (exp_done) begin
          state_next = LOCKED;
        end else if (sel_changed) begin
          state_next = UNLOCKED;
        end else if (exp_mis) begin
          state_next = UNLOCKED;
          err_next   = 1'b1;
        end
      end
      default: state_next = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= UNLOCKED;
      exp_a_reg     <= 1'b1;
      err_reg       <= 1'b0;
      match_a_reg   <= 1'b0;
      match_b_reg   <= 1'b0;
      count_a_reg   <= '0;
      count_b_reg   <= '0;
      last_word_reg <= LW_NONE;
    end else begin
      state_reg   <= state_next;
      exp_a_reg   <= expect_a;
      err_reg     <= err_next;
      match_a_reg <= done_a;
      match_b_reg <= done_b;
      if (done_a) count_a_reg <= count_a_reg + CNT_W'(1);
      if (done_b) count_b_reg <= count_b_reg + CNT_W'(1);
      if (done_a)      last_word_reg <= LW_A;
      else if (done_b) last_word_reg <= LW_B;
    end
  end

  assign match_a   = match_a_reg;
  assign match_b   = match_b_reg;
  assign count_a   = count_a_reg;
  assign count_b   = count_b_reg;
  assign last_word = last_word_reg;
  assign locked    = (state_reg == LOCKED);
  assign err       = err_reg;

endmodule
